// File: rtl/zap_wb_pkg.sv
// Shared types and constants for the writeback/commit stage: FSM states,
// exception kinds with their priority rule, and exception vector addresses.
package zap_wb_pkg;

    typedef enum logic [1:0] {
        WB_ACCEPT,
        WB_SECOND,
        WB_FLUSH
    } wb_state_t;

    typedef enum logic [2:0] {
        EXC_NONE,
        EXC_SWI,
        EXC_UND,
        EXC_PABT,
        EXC_IRQ,
        EXC_FIQ,
        EXC_DABT
    } exc_t;

    localparam logic [31:0] VEC_UND  = 32'h0000_0004;
    localparam logic [31:0] VEC_SWI  = 32'h0000_0008;
    localparam logic [31:0] VEC_PABT = 32'h0000_000C;
    localparam logic [31:0] VEC_DABT = 32'h0000_0010;
    localparam logic [31:0] VEC_IRQ  = 32'h0000_0018;
    localparam logic [31:0] VEC_FIQ  = 32'h0000_001C;

    // SVC mode with IRQ and FIQ masked.
    localparam logic [31:0] RESET_FLAGS = 32'h0000_01D3;

    function automatic exc_t exc_priority(input logic dabt, input logic fiq, input logic irq,
                                          input logic pabt, input logic und, input logic swi);
        if (dabt)      return EXC_DABT;
        else if (fiq)  return EXC_FIQ;
        else if (irq)  return EXC_IRQ;
        else if (pabt) return EXC_PABT;
        else if (und)  return EXC_UND;
        else if (swi)  return EXC_SWI;
        else           return EXC_NONE;
    endfunction

endpackage

// File: rtl/zap_writeback_commit_if.sv
// Memory-stage to commit-stage bundle: registered memory-stage results in,
// register-file write port, flush/redirect and exception signalling out.
interface zap_writeback_commit_if #(
    parameter int FLAG_WDT = 32,
    parameter int PHY_REGS = 46
);
    localparam int IDX_W = $clog2(PHY_REGS);

    logic                i_dav_ff;
    logic [31:0]         i_alu_result_ff;
    logic [FLAG_WDT-1:0] i_flags_ff;
    logic [IDX_W-1:0]    i_destination_index_ff;
    logic                i_mem_load_ff;
    logic [IDX_W-1:0]    i_mem_srcdest_index_ff;
    logic [31:0]         i_mem_rd_data;
    logic [31:0]         i_pc_plus_8_ff;
    logic                i_irq_ff;
    logic                i_fiq_ff;
    logic                i_swi_ff;
    logic                i_instr_abort_ff;
    logic                i_und_ff;
    logic [1:0]          i_mem_fault;

    logic                o_stall_from_wb;
    logic                o_wr_en;
    logic [IDX_W-1:0]    o_wr_index;
    logic [31:0]         o_wr_data;
    logic [FLAG_WDT-1:0] o_flags;
    logic                o_clear_from_writeback;
    logic [31:0]         o_pc_from_wb;
    logic                o_exc_valid;
    logic [31:0]         o_exc_return;
    logic [31:0]         o_retired;

    modport master (
        output i_dav_ff, i_alu_result_ff, i_flags_ff, i_destination_index_ff,
               i_mem_load_ff, i_mem_srcdest_index_ff, i_mem_rd_data, i_pc_plus_8_ff,
               i_irq_ff, i_fiq_ff, i_swi_ff, i_instr_abort_ff, i_und_ff, i_mem_fault,
        input  o_stall_from_wb, o_wr_en, o_wr_index, o_wr_data, o_flags,
               o_clear_from_writeback, o_pc_from_wb, o_exc_valid, o_exc_return, o_retired
    );

    modport slave (
        input  i_dav_ff, i_alu_result_ff, i_flags_ff, i_destination_index_ff,
               i_mem_load_ff, i_mem_srcdest_index_ff, i_mem_rd_data, i_pc_plus_8_ff,
               i_irq_ff, i_fiq_ff, i_swi_ff, i_instr_abort_ff, i_und_ff, i_mem_fault,
        output o_stall_from_wb, o_wr_en, o_wr_index, o_wr_data, o_flags,
               o_clear_from_writeback, o_pc_from_wb, o_exc_valid, o_exc_return, o_retired
    );

endinterface

// File: rtl/zap_wb_exc_prio.sv
// Combinational exception resolver: picks the winning exception and reports
// its vector and whether the banked return address is PC+8 or PC+4.
module zap_wb_exc_prio
    import zap_wb_pkg::*;
(
    input  logic        i_dabt,
    input  logic        i_fiq,
    input  logic        i_irq,
    input  logic        i_pabt,
    input  logic        i_und,
    input  logic        i_swi,
    output exc_t        o_exc,
    output logic [31:0] o_vector,
    output logic        o_ret_pc8
);

    always_comb begin
        o_exc     = exc_priority(i_dabt, i_fiq, i_irq, i_pabt, i_und, i_swi);
        o_vector  = '0;
        o_ret_pc8 = 1'b0;
        case (o_exc)
            EXC_DABT: begin o_vector = VEC_DABT; o_ret_pc8 = 1'b1; end
            EXC_FIQ:  o_vector = VEC_FIQ;
            EXC_IRQ:  o_vector = VEC_IRQ;
            EXC_PABT: o_vector = VEC_PABT;
            EXC_UND:  o_vector = VEC_UND;
            EXC_SWI:  o_vector = VEC_SWI;
            default:  ;
        endcase
    end

endmodule

// File: rtl/zap_writeback_commit.sv
// Commit stage: serialises up to two register writes onto one write port and
// turns exceptions and PC writes into a one-cycle flush plus redirect.
module zap_writeback_commit
    import zap_wb_pkg::*;
#(
    parameter int FLAG_WDT = 32,
    parameter int PHY_REGS = 46,
    parameter int RAZ_IDX  = PHY_REGS - 1,
    parameter int PC_IDX   = 15
) (
    input logic                   i_clk,
    input logic                   i_reset,
    zap_writeback_commit_if.slave wb
);

    localparam int IDX_W = $clog2(PHY_REGS);
    localparam logic [IDX_W-1:0] RAZ = IDX_W'(RAZ_IDX);
    localparam logic [IDX_W-1:0] PCI = IDX_W'(PC_IDX);

    wb_state_t state_q, state_d;

    logic                wr_en_q, wr_en_d;
    logic [IDX_W-1:0]    wr_index_q, wr_index_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [FLAG_WDT-1:0] flags_q, flags_d;
    logic                clear_q, clear_d;
    logic [31:0]         pc_q, pc_d;
    logic                exc_valid_q, exc_valid_d;
    logic [31:0]         exc_ret_q, exc_ret_d;
    logic [31:0]         retired_q, retired_d;

    logic [IDX_W-1:0]    ld_idx_q;
    logic [31:0]         ld_data_q;
    logic [FLAG_WDT-1:0] ld_flags_q;
    logic                alu_pc_q;
    logic [31:0]         alu_pc_data_q;

    exc_t        exc;
    logic [31:0] exc_vector;
    logic        exc_ret_pc8;

    logic             take, exc_take, two_writes, single_en, single_pc;
    logic [IDX_W-1:0] single_idx;
    logic [31:0]      single_data;

    zap_wb_exc_prio u_exc_prio (
        .i_dabt    (|wb.i_mem_fault),
        .i_fiq     (wb.i_fiq_ff),
        .i_irq     (wb.i_irq_ff),
        .i_pabt    (wb.i_instr_abort_ff),
        .i_und     (wb.i_und_ff),
        .i_swi     (wb.i_swi_ff),
        .o_exc     (exc),
        .o_vector  (exc_vector),
        .o_ret_pc8 (exc_ret_pc8)
    );

    // When both targets are distinct and live, the ALU write goes first and the load follows in SECOND.
    always_comb begin
        take       = (state_q == WB_ACCEPT) && wb.i_dav_ff;
        exc_take   = take && (exc != EXC_NONE);
        two_writes = take && !exc_take && wb.i_mem_load_ff &&
                     (wb.i_destination_index_ff != RAZ) &&
                     (wb.i_mem_srcdest_index_ff != RAZ) &&
                     (wb.i_destination_index_ff != wb.i_mem_srcdest_index_ff);
        if (wb.i_mem_load_ff && (wb.i_mem_srcdest_index_ff != RAZ)) begin
            single_en   = 1'b1;
            single_idx  = wb.i_mem_srcdest_index_ff;
            single_data = wb.i_mem_rd_data;
        end else begin
            single_en   = (wb.i_destination_index_ff != RAZ);
            single_idx  = wb.i_destination_index_ff;
            single_data = wb.i_alu_result_ff;
        end
        single_pc = single_en && (single_idx == PCI);
    end

    assign wb.o_stall_from_wb = two_writes;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= WB_ACCEPT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_ACCEPT: begin
                if (exc_take)                state_d = WB_FLUSH;
                else if (two_writes)         state_d = WB_SECOND;
                else if (take && single_pc)  state_d = WB_FLUSH;
                else                         state_d = WB_ACCEPT;
            end
            WB_SECOND: state_d = ((ld_idx_q == PCI) || alu_pc_q) ? WB_FLUSH : WB_ACCEPT;
            WB_FLUSH:  state_d = WB_ACCEPT;
            default:   state_d = WB_ACCEPT;
        endcase
    end

    // An ALU write to the PC in a two-write instruction defers its redirect to
    // SECOND so the load is not lost; a load into the PC, being later, wins.
    always_comb begin
        wr_en_d     = 1'b0;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
        flags_d     = flags_q;
        clear_d     = 1'b0;
        pc_d        = pc_q;
        exc_valid_d = 1'b0;
        exc_ret_d   = exc_ret_q;
        retired_d   = retired_q;
        case (state_q)
            WB_ACCEPT: begin
                if (exc_take) begin
                    exc_valid_d = 1'b1;
                    clear_d     = 1'b1;
                    pc_d        = exc_vector;
                    exc_ret_d   = exc_ret_pc8 ? wb.i_pc_plus_8_ff : wb.i_pc_plus_8_ff - 32'd4;
                end else if (two_writes) begin
                    wr_en_d    = 1'b1;
                    wr_index_d = wb.i_destination_index_ff;
                    wr_data_d  = wb.i_alu_result_ff;
                end else if (take) begin
                    wr_en_d    = single_en;
                    wr_index_d = single_idx;
                    wr_data_d  = single_data;
                    flags_d    = wb.i_flags_ff;
                    retired_d  = retired_q + 32'd1;
                    if (single_pc) begin
                        clear_d = 1'b1;
                        pc_d    = single_data;
                    end
                end
            end
            WB_SECOND: begin
                wr_en_d    = 1'b1;
                wr_index_d = ld_idx_q;
                wr_data_d  = ld_data_q;
                flags_d    = ld_flags_q;
                retired_d  = retired_q + 32'd1;
                if (ld_idx_q == PCI) begin
                    clear_d = 1'b1;
                    pc_d    = ld_data_q;
                end else if (alu_pc_q) begin
                    clear_d = 1'b1;
                    pc_d    = alu_pc_data_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_en_q       <= 1'b0;
            wr_index_q    <= '0;
            wr_data_q     <= '0;
            flags_q       <= FLAG_WDT'(RESET_FLAGS);
            clear_q       <= 1'b0;
            pc_q          <= '0;
            exc_valid_q   <= 1'b0;
            exc_ret_q     <= '0;
            retired_q     <= '0;
            ld_idx_q      <= '0;
            ld_data_q     <= '0;
            ld_flags_q    <= '0;
            alu_pc_q      <= 1'b0;
            alu_pc_data_q <= '0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
            flags_q     <= flags_d;
            clear_q     <= clear_d;
            pc_q        <= pc_d;
            exc_valid_q <= exc_valid_d;
            exc_ret_q   <= exc_ret_d;
            retired_q   <= retired_d;
            if (two_writes) begin
                ld_idx_q      <= wb.i_mem_srcdest_index_ff;
                ld_data_q     <= wb.i_mem_rd_data;
                ld_flags_q    <= wb.i_flags_ff;
                alu_pc_q      <= (wb.i_destination_index_ff == PCI);
                alu_pc_data_q <= wb.i_alu_result_ff;
            end
        end
    end

    assign wb.o_wr_en                = wr_en_q;
    assign wb.o_wr_index             = wr_index_q;
    assign wb.o_wr_data              = wr_data_q;
    assign wb.o_flags                = flags_q;
    assign wb.o_clear_from_writeback = clear_q;
    assign wb.o_pc_from_wb           = pc_q;
    assign wb.o_exc_valid            = exc_valid_q;
    assign wb.o_exc_return           = exc_ret_q;
    assign wb.o_retired              = retired_q;

    a_no_dav_in_second: assert property (@(posedge i_clk) disable iff (i_reset)
        (state_q == WB_SECOND) |-> !wb.i_dav_ff);
    a_clear_single_cycle: assert property (@(posedge i_clk) disable iff (i_reset)
        clear_q |=> !clear_q);

endmodule

// File: tb/tb_zap_writeback_commit.sv
// Bench for zap_writeback_commit: each accepted instruction is expanded into a
// queue of per-cycle output beats, and one process compares the DUT against it.
module tb_zap_writeback_commit;

    localparam int FLAG_WDT = 32;
    localparam int PHY_REGS = 46;
    localparam int RAZ_IDX  = 45;
    localparam int PC_IDX   = 15;

    typedef struct {
        bit        dav, load, irq, fiq, swi, pabt, und;
        bit [1:0]  fault;
        bit [5:0]  dest, sd;
        bit [31:0] alu, rd, pc8, flags;
    } ins_t;

    typedef struct {
        bit        wr, retire, clear, exc, shadow;
        bit [5:0]  idx;
        bit [31:0] data, flags, pc, ret;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zap_writeback_commit_if #(.FLAG_WDT(FLAG_WDT), .PHY_REGS(PHY_REGS)) bus ();

    zap_writeback_commit #(
        .FLAG_WDT (FLAG_WDT),
        .PHY_REGS (PHY_REGS),
        .RAZ_IDX  (RAZ_IDX),
        .PC_IDX   (PC_IDX)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wb      (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    beat_t     plan[$];
    bit        exp_stall, exp_wr, exp_clear, exp_exc;
    bit [5:0]  exp_idx;
    bit [31:0] exp_data, exp_flags, exp_pc, exp_ret, exp_retired;
    bit        stall_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    endtask

    function automatic bit has_exc(input ins_t t);
        return (t.fault != 2'b00) || t.fiq || t.irq || t.pabt || t.und || t.swi;
    endfunction

    function automatic bit needs_two(input ins_t t);
        return t.load && (t.dest != 6'(RAZ_IDX)) && (t.sd != 6'(RAZ_IDX)) && (t.dest != t.sd);
    endfunction

    function automatic void model_reset();
        plan.delete();
        exp_stall = 0; exp_wr = 0; exp_clear = 0; exp_exc = 0;
        exp_idx = '0; exp_data = '0; exp_pc = '0; exp_ret = '0; exp_retired = '0;
        exp_flags = 32'h1D3;
    endfunction

    function automatic void apply(input beat_t b);
        exp_wr    = b.wr;
        exp_clear = b.clear;
        exp_exc   = b.exc;
        if (b.wr) begin exp_idx = b.idx; exp_data = b.data; end
        if (b.retire) begin exp_retired = exp_retired + 1; exp_flags = b.flags; end
        if (b.clear) exp_pc = b.pc;
        if (b.exc) exp_ret = b.ret;
    endfunction

    // Turn one accepted instruction into the sequence of cycles it occupies.
    function automatic void expand(input ins_t t);
        beat_t       b;
        bit [5:0]    wi[2];
        bit [31:0]   wd[2];
        int unsigned nw;
        bit          pcw;
        bit [31:0]   pcv;
        b = '{default: 0};
        if (has_exc(t)) begin
            b.exc = 1; b.clear = 1; b.ret = t.pc8 - 4;
            if (t.fault != 0) begin b.pc = 32'h10; b.ret = t.pc8; end
            else if (t.fiq)   b.pc = 32'h1C;
            else if (t.irq)   b.pc = 32'h18;
            else if (t.pabt)  b.pc = 32'h0C;
            else if (t.und)   b.pc = 32'h04;
            else              b.pc = 32'h08;
            plan.push_back(b);
            b = '{default: 0}; b.shadow = 1;
            plan.push_back(b);
            return;
        end
        nw = 0;
        if (needs_two(t)) begin
            wi[0] = t.dest; wd[0] = t.alu; wi[1] = t.sd; wd[1] = t.rd; nw = 2;
        end else if (t.load && t.sd != 6'(RAZ_IDX)) begin
            wi[0] = t.sd; wd[0] = t.rd; nw = 1;
        end else if (t.dest != 6'(RAZ_IDX)) begin
            wi[0] = t.dest; wd[0] = t.alu; nw = 1;
        end
        pcw = 0; pcv = '0;
        for (int unsigned i = 0; i < nw; i++)
            if (wi[i] == 6'(PC_IDX)) begin pcw = 1; pcv = wd[i]; end
        if (nw == 0) begin
            b.retire = 1; b.flags = t.flags;
            plan.push_back(b);
        end
        for (int unsigned i = 0; i < nw; i++) begin
            b = '{default: 0};
            b.wr = 1; b.idx = wi[i]; b.data = wd[i];
            if (i == nw - 1) begin
                b.retire = 1; b.flags = t.flags; b.clear = pcw; b.pc = pcv;
            end
            plan.push_back(b);
        end
        if (pcw) begin
            b = '{default: 0}; b.shadow = 1;
            plan.push_back(b);
        end
    endfunction

    task automatic drive(input ins_t t);
        bus.i_dav_ff               = t.dav;
        bus.i_alu_result_ff        = t.alu;
        bus.i_flags_ff             = t.flags;
        bus.i_destination_index_ff = t.dest;
        bus.i_mem_load_ff          = t.load;
        bus.i_mem_srcdest_index_ff = t.sd;
        bus.i_mem_rd_data          = t.rd;
        bus.i_pc_plus_8_ff         = t.pc8;
        bus.i_irq_ff               = t.irq;
        bus.i_fiq_ff               = t.fiq;
        bus.i_swi_ff               = t.swi;
        bus.i_instr_abort_ff       = t.pabt;
        bus.i_und_ff               = t.und;
        bus.i_mem_fault            = t.fault;
    endtask

    task automatic cycle(input ins_t t_in);
        ins_t  t;
        beat_t idle_b;
        t = t_in;
        idle_b = '{default: 0};
        @(negedge clk); #1;
        if (plan.size() != 0 && !plan[0].shadow) t.dav = 0;
        drive(t);
        exp_stall = (plan.size() == 0) && t.dav && !has_exc(t) && needs_two(t);
        #2 stall_seen = bus.o_stall_from_wb;
        @(posedge clk); #1;
        if (plan.size() != 0) apply(plan.pop_front());
        else if (t.dav) begin expand(t); apply(plan.pop_front()); end
        else apply(idle_b);
    endtask

    task automatic reset_pulse();
        ins_t idle;
        idle = '{default: 0};
        @(negedge clk); #1;
        rst = 1;
        drive(idle);
        model_reset();
        #1;
        chk("rst_async_wr_en", 32'(bus.o_wr_en), 32'd0);
        chk("rst_async_retired", bus.o_retired, 32'd0);
        chk("rst_async_flags", bus.o_flags, 32'h1D3);
        @(negedge clk); #1;
        rst = 0;
    endtask

    function automatic bit [5:0] pick_idx();
        case ($urandom_range(0, 9))
            6:       return 6'(PC_IDX);
            7, 8:    return 6'(RAZ_IDX);
            9:       return 6'($urandom_range(0, RAZ_IDX - 1));
            default: return 6'($urandom_range(0, 5));
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t t;
        t.dav   = ($urandom_range(0, 3) != 0);
        t.alu   = $urandom; t.rd = $urandom; t.flags = $urandom; t.pc8 = $urandom;
        t.dest  = pick_idx(); t.sd = pick_idx();
        t.load  = 1'($urandom_range(0, 1));
        t.irq   = ($urandom_range(0, 15) == 0);
        t.fiq   = ($urandom_range(0, 15) == 0);
        t.swi   = ($urandom_range(0, 15) == 0);
        t.pabt  = ($urandom_range(0, 15) == 0);
        t.und   = ($urandom_range(0, 15) == 0);
        t.fault = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    // Single compare process: registered outputs plus the combinational stall.
    initial begin
        forever begin
            @(negedge clk); #2;
            chk("stall", 32'(bus.o_stall_from_wb), 32'(exp_stall));
            chk("wr_en", 32'(bus.o_wr_en), 32'(exp_wr));
            if (exp_wr) begin
                chk("wr_index", 32'(bus.o_wr_index), 32'(exp_idx));
                chk("wr_data", bus.o_wr_data, exp_data);
            end
            chk("flags", bus.o_flags, exp_flags);
            chk("clear", 32'(bus.o_clear_from_writeback), 32'(exp_clear));
            if (exp_clear) chk("pc_from_wb", bus.o_pc_from_wb, exp_pc);
            chk("exc_valid", 32'(bus.o_exc_valid), 32'(exp_exc));
            if (exp_exc) chk("exc_return", bus.o_exc_return, exp_ret);
            chk("retired", bus.o_retired, exp_retired);
        end
    end

    initial begin
        ins_t        idle, t;
        logic [31:0] r0;
        idle = '{default: 0};
        idle.dest = 6'(RAZ_IDX); idle.sd = 6'(RAZ_IDX);
        model_reset();
        drive(idle);
        repeat (2) @(negedge clk);
        chk("reset_flags", bus.o_flags, 32'h1D3);
        chk("reset_retired", bus.o_retired, 32'd0);
        #1 rst = 0;

        // Post-indexed load: base writeback then loaded value.
        r0 = bus.o_retired;
        t = idle; t.dav = 1; t.load = 1; t.dest = 6'd1; t.sd = 6'd3;
        t.alu = 32'h104; t.rd = 32'hCAFE0000; t.flags = 32'h6000_0010;
        cycle(t);
        chk("t1_stall", 32'(stall_seen), 32'd1);
        chk("t1_w1_idx", 32'(bus.o_wr_index), 32'd1);
        chk("t1_w1_data", bus.o_wr_data, 32'h104);
        chk("t1_no_retire_yet", bus.o_retired, r0);
        cycle(idle);
        chk("t1_stall2", 32'(stall_seen), 32'd0);
        chk("t1_w2_idx", 32'(bus.o_wr_index), 32'd3);
        chk("t1_w2_data", bus.o_wr_data, 32'hCAFE0000);
        chk("t1_retired", bus.o_retired, r0 + 32'd1);
        chk("t1_flags", bus.o_flags, 32'h6000_0010);

        // Load where base and destination coincide: one write of load data.
        t = idle; t.dav = 1; t.load = 1; t.dest = 6'd5; t.sd = 6'd5;
        t.alu = 32'h55; t.rd = 32'h1234_5678;
        cycle(t);
        chk("t2_stall", 32'(stall_seen), 32'd0);
        chk("t2_idx", 32'(bus.o_wr_index), 32'd5);
        chk("t2_data", bus.o_wr_data, 32'h1234_5678);

        // ALU write to PC, then a shadow instruction that must vanish.
        t = idle; t.dav = 1; t.dest = 6'(PC_IDX); t.alu = 32'h8000;
        cycle(t);
        chk("t3_clear", 32'(bus.o_clear_from_writeback), 32'd1);
        chk("t3_pc", bus.o_pc_from_wb, 32'h8000);
        t = idle; t.dav = 1; t.dest = 6'd2; t.alu = 32'hDEAD;
        cycle(t);
        chk("t3_shadow_wr", 32'(bus.o_wr_en), 32'd0);
        chk("t3_clear_drop", 32'(bus.o_clear_from_writeback), 32'd0);

        // Data abort beats a simultaneous IRQ.
        t = idle; t.dav = 1; t.fault = 2'b01; t.irq = 1; t.pc8 = 32'h208; t.dest = 6'd4;
        cycle(t);
        chk("t4_vec", bus.o_pc_from_wb, 32'h10);
        chk("t4_ret", bus.o_exc_return, 32'h208);
        chk("t4_wr_en", 32'(bus.o_wr_en), 32'd0);
        chk("t4_exc", 32'(bus.o_exc_valid), 32'd1);
        cycle(idle);

        // IRQ alone, with a back-to-back instruction in the flush cycle.
        t = idle; t.dav = 1; t.irq = 1; t.pc8 = 32'h108;
        cycle(t);
        chk("t5_vec", bus.o_pc_from_wb, 32'h18);
        chk("t5_ret", bus.o_exc_return, 32'h104);
        t = idle; t.dav = 1; t.dest = 6'd4; t.alu = 32'h77;
        cycle(t);
        chk("t5_shadow_wr", 32'(bus.o_wr_en), 32'd0);
        chk("t5_exc_drop", 32'(bus.o_exc_valid), 32'd0);

        // Reset while the second write is pending.
        t = idle; t.dav = 1; t.load = 1; t.dest = 6'd7; t.sd = 6'd8;
        t.alu = 32'h11; t.rd = 32'h22;
        cycle(t);
        reset_pulse();
        cycle(idle);
        chk("t6_no_pending", 32'(bus.o_wr_en), 32'd0);

        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) reset_pulse();
            cycle(rand_ins());
        end
        repeat (3) cycle(idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
